// File: rtl/vx_vec_wb_collector_pkg.sv
`default_nettype none
// ============================================================================
// vx_vec_wb_collector_pkg : shared widths and beat/VRF/release record types
// Rev 1.0 : initial release
// ============================================================================
package vx_vec_wb_collector_pkg;

  localparam int NUM_THREADS = 4;
  localparam int XLEN        = 32;
  localparam int NR_BITS     = 6;
  localparam int ISSUE_WIS_W = 2;
  localparam int UUID_W      = 8;
  localparam int PC_W        = 32;
  localparam int NUM_WIS     = 1 << ISSUE_WIS_W;

  typedef struct packed {
    logic [UUID_W-1:0]           uuid;
    logic [ISSUE_WIS_W-1:0]      wis;
    logic [NUM_THREADS-1:0]      tmask;
    logic [PC_W-1:0]             pc;
    logic [NR_BITS-1:0]          rd;
    logic [NUM_THREADS*XLEN-1:0] data;
    logic                        sop;
    logic                        eop;
    logic                        is_vec;
    logic [NR_BITS-1:0]          vd;
    logic [NR_BITS-1:0]          lane_id;
  } wb_data_t;

  localparam int WB_DATA_W = $bits(wb_data_t);

  typedef struct packed {
    logic [ISSUE_WIS_W-1:0]      wis;
    logic [NR_BITS-1:0]          vd;
    logic [NR_BITS-1:0]          lane_id;
    logic [NUM_THREADS-1:0]      tmask;
    logic [NUM_THREADS*XLEN-1:0] data;
    logic                        eop;
  } vrf_req_t;

  localparam int VRF_REQ_W = $bits(vrf_req_t);

  typedef struct packed {
    logic [ISSUE_WIS_W-1:0] wis;
    logic [NR_BITS-1:0]     regno;
    logic                   is_vec;
  } rel_t;

  // A packet must open with sop exactly when the warp is not already inside one.
  function automatic logic seq_violation(input logic sop, input logic in_pkt);
    return sop == in_pkt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vx_vec_wb_collector_fifo.sv
`default_nettype none
// ============================================================================
// vx_vec_wb_collector_fifo : power-of-two FIFO queue with first-word fall-through
// Rev 1.0 : initial release
// ============================================================================
module vx_vec_wb_collector_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign data_out = mem_q[rd_ptr_q];

  // A push into a full queue is only accepted when the head leaves the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vx_vec_wb_collector.sv
`default_nettype none
// ============================================================================
// vx_vec_wb_collector : splits writeback beats into scalar GPR writes and
// buffered vector VRF writes, and arbitrates scoreboard releases.
// Rev 1.0 : initial release
// ============================================================================
module vx_vec_wb_collector
  import vx_vec_wb_collector_pkg::*;
#(
  parameter int FIFO_DEPTH = 4  // power of two, >= 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wb_valid,
  input  logic [WB_DATA_W-1:0]          wb_data,
  output logic                          gpr_we,
  output logic [ISSUE_WIS_W-1:0]        gpr_wis,
  output logic [NR_BITS-1:0]            gpr_rd,
  output logic [NUM_THREADS-1:0]        gpr_tmask,
  output logic [NUM_THREADS*XLEN-1:0]   gpr_data,
  output logic                          vrf_valid,
  input  logic                          vrf_ready,
  output logic [ISSUE_WIS_W-1:0]        vrf_wis,
  output logic [NR_BITS-1:0]            vrf_vd,
  output logic [NR_BITS-1:0]            vrf_lane_id,
  output logic [NUM_THREADS-1:0]        vrf_tmask,
  output logic [NUM_THREADS*XLEN-1:0]   vrf_data,
  output logic                          rel_valid,
  output logic [ISSUE_WIS_W-1:0]        rel_wis,
  output logic [NR_BITS-1:0]            rel_reg,
  output logic                          rel_is_vec,
  output logic                          err_overflow,
  output logic                          err_seq
);

  wb_data_t beat;
  logic     scalar_beat, vec_beat;
  logic     unused_fields;

  assign beat          = wb_data;
  assign scalar_beat   = wb_valid && !beat.is_vec;
  assign vec_beat      = wb_valid && beat.is_vec;
  assign unused_fields = ^{beat.uuid, beat.pc};

  logic                        gpr_we_q,    gpr_we_d;
  logic [ISSUE_WIS_W-1:0]      gpr_wis_q,   gpr_wis_d;
  logic [NR_BITS-1:0]          gpr_rd_q,    gpr_rd_d;
  logic [NUM_THREADS-1:0]      gpr_tmask_q, gpr_tmask_d;
  logic [NUM_THREADS*XLEN-1:0] gpr_data_q,  gpr_data_d;
  logic                        sc_rel_q,    sc_rel_d;
  logic                        pend_q,      pend_d;
  rel_t                        pend_rel_q,  pend_rel_d;
  logic [NUM_WIS-1:0]          in_pkt_q,    in_pkt_d;
  logic                        err_ovf_q,   err_ovf_d;
  logic                        err_seq_q,   err_seq_d;

  vrf_req_t push_req, head_req;
  logic     fifo_empty, fifo_full, head_valid, pop;

  assign push_req = '{wis: beat.wis, vd: beat.vd, lane_id: beat.lane_id,
                      tmask: beat.tmask, data: beat.data, eop: beat.eop};

  vx_vec_wb_collector_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (VRF_REQ_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (vec_beat),
    .pop      (pop),
    .data_in  (push_req),
    .data_out (head_req),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // The release slot holds one packet; a second eop must wait until it drains.
  assign head_valid = !fifo_empty && !(pend_q && head_req.eop);
  assign pop        = head_valid && vrf_ready;

  always_comb begin
    gpr_we_d    = scalar_beat;
    sc_rel_d    = scalar_beat && beat.eop;
    gpr_wis_d   = gpr_wis_q;
    gpr_rd_d    = gpr_rd_q;
    gpr_tmask_d = gpr_tmask_q;
    gpr_data_d  = gpr_data_q;
    pend_d      = pend_q;
    pend_rel_d  = pend_rel_q;
    in_pkt_d    = in_pkt_q;
    err_ovf_d   = err_ovf_q || (vec_beat && fifo_full && !pop);
    err_seq_d   = err_seq_q;

    if (scalar_beat) begin
      gpr_wis_d   = beat.wis;
      gpr_rd_d    = beat.rd;
      gpr_tmask_d = beat.tmask;
      gpr_data_d  = beat.data;
    end

    // Scalar releases win the port; the vector release simply waits.
    if (pend_q && !sc_rel_q) begin
      pend_d = 1'b0;
    end
    if (pop && head_req.eop) begin
      pend_d     = 1'b1;
      pend_rel_d = '{wis: head_req.wis, regno: head_req.vd, is_vec: 1'b1};
    end

    if (wb_valid) begin
      if (seq_violation(beat.sop, in_pkt_q[beat.wis])) begin
        err_seq_d = 1'b1;
      end
      in_pkt_d[beat.wis] = !beat.eop && (beat.sop || in_pkt_q[beat.wis]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpr_we_q    <= 1'b0;
      gpr_wis_q   <= '0;
      gpr_rd_q    <= '0;
      gpr_tmask_q <= '0;
      gpr_data_q  <= '0;
      sc_rel_q    <= 1'b0;
      pend_q      <= 1'b0;
      pend_rel_q  <= '0;
      in_pkt_q    <= '0;
      err_ovf_q   <= 1'b0;
      err_seq_q   <= 1'b0;
    end else begin
      gpr_we_q    <= gpr_we_d;
      gpr_wis_q   <= gpr_wis_d;
      gpr_rd_q    <= gpr_rd_d;
      gpr_tmask_q <= gpr_tmask_d;
      gpr_data_q  <= gpr_data_d;
      sc_rel_q    <= sc_rel_d;
      pend_q      <= pend_d;
      pend_rel_q  <= pend_rel_d;
      in_pkt_q    <= in_pkt_d;
      err_ovf_q   <= err_ovf_d;
      err_seq_q   <= err_seq_d;
    end
  end

  // Outputs are forced low while reset is asserted, not just after the edge.
  assign gpr_we       = !reset && gpr_we_q;
  assign gpr_wis      = gpr_we ? gpr_wis_q   : '0;
  assign gpr_rd       = gpr_we ? gpr_rd_q    : '0;
  assign gpr_tmask    = gpr_we ? gpr_tmask_q : '0;
  assign gpr_data     = gpr_we ? gpr_data_q  : '0;

  assign vrf_valid    = !reset && head_valid;
  assign vrf_wis      = vrf_valid ? head_req.wis     : '0;
  assign vrf_vd       = vrf_valid ? head_req.vd      : '0;
  assign vrf_lane_id  = vrf_valid ? head_req.lane_id : '0;
  assign vrf_tmask    = vrf_valid ? head_req.tmask   : '0;
  assign vrf_data     = vrf_valid ? head_req.data    : '0;

  assign rel_valid    = !reset && (sc_rel_q || pend_q);
  assign rel_wis      = !rel_valid ? '0 : (sc_rel_q ? gpr_wis_q : pend_rel_q.wis);
  assign rel_reg      = !rel_valid ? '0 : (sc_rel_q ? gpr_rd_q  : pend_rel_q.regno);
  assign rel_is_vec   = rel_valid && !sc_rel_q && pend_rel_q.is_vec;

  assign err_overflow = !reset && err_ovf_q;
  assign err_seq      = !reset && err_seq_q;

endmodule
`default_nettype wire

// File: tb/tb_vx_vec_wb_collector.sv
`default_nettype none
// ============================================================================
// tb_vx_vec_wb_collector : directed table-driven bench for vx_vec_wb_collector
// Rev 1.0 : initial release
// ============================================================================
module tb_vx_vec_wb_collector;
  import vx_vec_wb_collector_pkg::*;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        wb_valid;
  logic [WB_DATA_W-1:0]        wb_data;
  logic                        gpr_we;
  logic [ISSUE_WIS_W-1:0]      gpr_wis;
  logic [NR_BITS-1:0]          gpr_rd;
  logic [NUM_THREADS-1:0]      gpr_tmask;
  logic [NUM_THREADS*XLEN-1:0] gpr_data;
  logic                        vrf_valid, vrf_ready;
  logic [ISSUE_WIS_W-1:0]      vrf_wis;
  logic [NR_BITS-1:0]          vrf_vd, vrf_lane_id;
  logic [NUM_THREADS-1:0]      vrf_tmask;
  logic [NUM_THREADS*XLEN-1:0] vrf_data;
  logic                        rel_valid, rel_is_vec;
  logic [ISSUE_WIS_W-1:0]      rel_wis;
  logic [NR_BITS-1:0]          rel_reg;
  logic                        err_overflow, err_seq;

  vx_vec_wb_collector #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_data(wb_data),
    .gpr_we(gpr_we), .gpr_wis(gpr_wis), .gpr_rd(gpr_rd), .gpr_tmask(gpr_tmask),
    .gpr_data(gpr_data), .vrf_valid(vrf_valid), .vrf_ready(vrf_ready),
    .vrf_wis(vrf_wis), .vrf_vd(vrf_vd), .vrf_lane_id(vrf_lane_id),
    .vrf_tmask(vrf_tmask), .vrf_data(vrf_data), .rel_valid(rel_valid),
    .rel_wis(rel_wis), .rel_reg(rel_reg), .rel_is_vec(rel_is_vec),
    .err_overflow(err_overflow), .err_seq(err_seq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct { logic [5:0] lane; logic [5:0] vd; logic [127:0] data; } vw_t;
  typedef struct { int cyc; logic [5:0] regno; logic is_vec; logic [1:0] wis; } rl_t;
  vw_t vlog[$];
  rl_t rlog[$];

  // Observed handshakes and releases, sampled mid-cycle.
  always @(negedge clk) begin
    #1;
    if (vrf_valid && vrf_ready) vlog.push_back('{vrf_lane_id, vrf_vd, vrf_data});
    if (rel_valid) rlog.push_back('{cyc, rel_reg, rel_is_vec, rel_wis});
  end

  typedef struct packed {
    logic valid; logic [1:0] wis; logic [5:0] rd; logic [3:0] tmask;
    logic sop; logic eop; logic [127:0] data;
    logic exp_we; logic exp_rel; logic exp_err_seq;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic beat(input logic v, input logic [1:0] wis, input logic [5:0] r,
                      input logic [5:0] lane, input logic [3:0] tm, input logic sop,
                      input logic eop, input logic isv, input logic [127:0] d);
    wb_data_t b;
    b = '0;
    b.uuid = 8'h3C; b.pc = 32'h8000_0000;
    b.wis = wis; b.rd = r; b.vd = r; b.lane_id = lane; b.tmask = tm;
    b.sop = sop; b.eop = eop; b.is_vec = isv; b.data = d;
    wb_valid = v;
    wb_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); wb_valid = 1'b0; end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; wb_valid = 1'b0; vrf_ready = 1'b0;
    @(negedge clk); @(negedge clk); reset = 1'b0;
    vlog.delete(); rlog.delete();
  endtask

  function automatic logic [127:0] vdata(input int l);
    return {32'hDA7A_0000 | 32'(l), 32'(l * 3), 32'h5A5A_5A5A, 32'(l + 100)};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wb_valid = 1'b0; vrf_ready = 1'b0; wb_data = '0;
    repeat (2) @(negedge clk);
    beat(1, 2'd1, 6'd5, 6'd0, 4'hF, 1, 1, 0, 128'h1);
    @(posedge clk); #1;
    chk("reset_gpr_we", gpr_we, 0);
    chk("reset_rel_valid", rel_valid, 0);
    chk("reset_vrf_valid", vrf_valid, 0);
    chk("reset_errs", {err_overflow, err_seq}, 0);
    @(negedge clk); reset = 1'b0; wb_valid = 1'b0;
    @(posedge clk); #1;
    chk("reset_beat_ignored", gpr_we, 0);

    // Scalar path: each row's effect appears one cycle after it is driven.
    tbl[0] = '{1'b1, 2'd1, 6'd5, 4'hF, 1'b1, 1'b1, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 2'd2, 6'd7, 4'h3, 1'b1, 1'b0, 128'hFFFF_0000_FFFF_0000_1234_5678_9ABC_DEF0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 2'd2, 6'd7, 4'h0, 1'b0, 1'b1, 128'h0000_0000_0000_0000_0000_0000_0000_00AA, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 2'd0, 6'd0, 4'h0, 1'b0, 1'b0, 128'h0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 2'd3, 6'd9, 4'h5, 1'b0, 1'b1, 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      beat(tbl[i].valid, tbl[i].wis, tbl[i].rd, 6'd0, tbl[i].tmask, tbl[i].sop, tbl[i].eop, 0, tbl[i].data);
      @(posedge clk); #1;
      chk($sformatf("row%0d_gpr_we", i), gpr_we, tbl[i].exp_we);
      if (tbl[i].exp_we) begin
        chk($sformatf("row%0d_gpr_fields", i), {gpr_wis, gpr_rd, gpr_tmask}, {tbl[i].wis, tbl[i].rd, tbl[i].tmask});
        chk($sformatf("row%0d_gpr_data", i), gpr_data, tbl[i].data);
      end
      chk($sformatf("row%0d_rel_valid", i), rel_valid, tbl[i].exp_rel);
      if (tbl[i].exp_rel)
        chk($sformatf("row%0d_rel_fields", i), {rel_wis, rel_reg, rel_is_vec}, {tbl[i].wis, tbl[i].rd, 1'b0});
      chk($sformatf("row%0d_err_seq", i), err_seq, tbl[i].exp_err_seq);
    end
    idle(1);

    // Four-lane vector packet with VRF always ready.
    do_reset();
    chk("b_err_seq_cleared", err_seq, 0);
    vrf_ready = 1'b1;
    for (int l = 0; l < 4; l++) begin
      @(negedge clk);
      beat(1, 2'd0, 6'd8, 6'(l), 4'hF, l == 0, l == 3, 1, vdata(l));
      if (l == 0) begin #1; chk("b_no_same_cycle_valid", vrf_valid, 0); end
    end
    idle(7);
    chk("b_vrf_count", vlog.size(), 4);
    for (int i = 0; i < vlog.size(); i++) begin
      chk($sformatf("b_lane%0d", i), {vlog[i].lane, vlog[i].vd}, {6'(i), 6'd8});
      chk($sformatf("b_data%0d", i), vlog[i].data, vdata(i));
    end
    chk("b_rel_count", rlog.size(), 1);
    if (rlog.size() > 0) chk("b_rel", {rlog[0].regno, rlog[0].is_vec}, {6'd8, 1'b1});
    chk("b_errs", {err_overflow, err_seq}, 0);

    // Overflow with VRF stalled, then push+pop on a full queue.
    do_reset();
    for (int l = 0; l < 5; l++) begin
      @(negedge clk);
      beat(1, 2'd0, 6'd20, 6'(l), 4'hF, l == 0, 0, 1, vdata(l));
    end
    @(negedge clk); wb_valid = 1'b0; #1;
    chk("c_err_overflow", err_overflow, 1);
    chk("c_head_valid", {vrf_valid, vrf_lane_id}, {1'b1, 6'd0});
    @(negedge clk); #1;
    chk("c_head_hold", {vrf_valid, vrf_lane_id, vrf_vd}, {1'b1, 6'd0, 6'd20});
    chk("c_head_hold_data", vrf_data, vdata(0));
    @(negedge clk);
    vrf_ready = 1'b1;
    beat(1, 2'd0, 6'd20, 6'd5, 4'hF, 0, 1, 1, vdata(5));
    idle(9);
    chk("c_vrf_count", vlog.size(), 5);
    for (int i = 0; i < vlog.size(); i++)
      chk($sformatf("c_lane_order%0d", i), vlog[i].lane, (i < 4) ? 6'(i) : 6'd5);
    chk("c_rel_count", rlog.size(), 1);
    if (rlog.size() > 0) chk("c_rel", {rlog[0].regno, rlog[0].is_vec}, {6'd20, 1'b1});
    chk("c_err_seq", err_seq, 0);

    // Scalar release beats a coincident vector release; second eop waits on the slot.
    do_reset();
    @(negedge clk); beat(1, 2'd0, 6'd12, 6'd0, 4'hF, 1, 1, 1, vdata(12));
    @(negedge clk); beat(1, 2'd0, 6'd13, 6'd0, 4'hF, 1, 1, 1, vdata(13));
    @(negedge clk); vrf_ready = 1'b1; beat(1, 2'd1, 6'd20, 6'd0, 4'h1, 1, 1, 0, 128'hBEEF);
    @(posedge clk); #1;
    chk("d_scalar_first", {rel_valid, rel_reg, rel_is_vec}, {1'b1, 6'd20, 1'b0});
    chk("d_eop_blocked", vrf_valid, 0);
    idle(9);
    chk("d_rel_count", rlog.size(), 3);
    if (rlog.size() == 3) begin
      chk("d_rel0", {rlog[0].regno, rlog[0].is_vec, rlog[0].wis}, {6'd20, 1'b0, 2'd1});
      chk("d_rel1", {rlog[1].regno, rlog[1].is_vec}, {6'd12, 1'b1});
      chk("d_rel1_cycle", rlog[1].cyc - rlog[0].cyc, 1);
      chk("d_rel2", {rlog[2].regno, rlog[2].is_vec}, {6'd13, 1'b1});
    end
    chk("d_vrf_count", vlog.size(), 2);

    // Reset with entries queued discards them silently.
    do_reset();
    for (int l = 0; l < 3; l++) begin
      @(negedge clk);
      beat(1, 2'd0, 6'd30, 6'(l), 4'hF, l == 0, l == 2, 1, vdata(l));
    end
    idle(1); #1;
    chk("e_queued_valid", vrf_valid, 1);
    @(negedge clk); reset = 1'b1; vrf_ready = 1'b1; #1;
    chk("e_in_reset", {vrf_valid, rel_valid}, 0);
    @(negedge clk); @(negedge clk); reset = 1'b0; #1;
    chk("e_empty_after", vrf_valid, 0);
    idle(4);
    chk("e_no_writes", vlog.size(), 0);
    chk("e_no_release", rlog.size(), 0);
    @(negedge clk); beat(1, 2'd2, 6'd31, 6'd7, 4'h2, 1, 1, 1, vdata(7));
    idle(5);
    chk("e_post_reset_write", vlog.size(), 1);
    if (vlog.size() == 1) chk("e_post_reset_lane", {vlog[0].lane, vlog[0].vd}, {6'd7, 6'd31});
    chk("e_post_reset_rel", rlog.size(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vx_vec_wb_collector.md
VX_VEC_WB_COLLECTOR -- requirements
Module: VX_vec_wb_collector

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, vector-write buffer entries; SHALL be a power of two and at least 2.
REQ-002 The block SHALL use one clock, clk, and a synchronous active-high reset, reset.
REQ-003 clk  input  1  clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 wb_valid  input  1  writeback beat valid; no backpressure exists upstream.
REQ-006 wb_data  input  VX_writeback_if data_t  beat fields: uuid, wis, tmask, PC, rd, data, sop, eop, is_vec, vd, lane_id.
REQ-007 gpr_we  output  1  scalar register-file write strobe.
REQ-008 gpr_wis / gpr_rd / gpr_tmask / gpr_data  output  ISSUE_WIS_W / NR_BITS / NUM_THREADS / NUM_THREADS*XLEN  scalar write fields.
REQ-009 vrf_valid  output  1  vector register-file write request.
REQ-010 vrf_ready  input  1  VRF accepts the request this cycle.
REQ-011 vrf_wis / vrf_vd / vrf_lane_id / vrf_tmask / vrf_data  output  ISSUE_WIS_W / NR_BITS / NR_BITS / NUM_THREADS / NUM_THREADS*XLEN  vector write fields.
REQ-012 rel_valid  output  1  one-cycle scoreboard release pulse.
REQ-013 rel_wis / rel_reg / rel_is_vec  output  ISSUE_WIS_W / NR_BITS / 1  released warp, register, register-file select.
REQ-014 err_overflow / err_seq  output  1 each  sticky error flags.

Function
REQ-015 A scalar beat (wb_valid, is_vec=0) SHALL produce gpr_we=1 with its fields exactly one cycle later; gpr_we SHALL be 0 otherwise.
REQ-016 A scalar beat with eop=1 SHALL raise rel_valid in the same cycle as its gpr_we, with rel_reg=rd and rel_is_vec=0.
REQ-017 A vector beat (wb_valid, is_vec=1) SHALL push {wis, vd, lane_id, tmask, data, eop} into the FIFO; vrf_valid SHALL rise no earlier than the next cycle.
REQ-018 An entry SHALL retire only on vrf_valid && vrf_ready; outputs SHALL hold stable while vrf_valid=1 and vrf_ready=0; retirement order SHALL equal push order.
REQ-019 Retiring an eop entry SHALL load a one-entry pending release {wis, vd}; a pending release SHALL raise rel_valid with rel_is_vec=1 in the first cycle no scalar release occurs (scalar has priority).
REQ-020 While a pending release is held and the FIFO head has eop=1, vrf_valid SHALL be 0.
REQ-021 FIFO empty: vrf_valid=0. Push while full without a same-cycle pop: beat dropped, err_overflow set. Push and pop in one cycle when full: both performed, occupancy unchanged.
REQ-022 Occupancy counter SHALL be clog2(FIFO_DEPTH)+1 bits; read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 Per-wis in_pkt bit: sop sets it, eop clears it, sop&eop leaves it clear; a beat with sop while in_pkt, or without sop while !in_pkt, SHALL set err_seq and still be processed.
REQ-024 A beat with tmask=0 SHALL still be written and released normally.

Reset
REQ-025 During reset, all outputs SHALL be 0; FIFO, pending release, in_pkt bits and error flags SHALL be cleared; wb_valid SHALL be ignored.
REQ-026 Reset mid-operation SHALL discard buffered entries and pending releases without emitting rel_valid.

Structure
REQ-027 The VRF-write and release struct typedefs SHALL live in VX_gpu_pkg.
REQ-028 The vector buffer SHALL be one VX_fifo_queue instance; the sequence check, release arbitration and scalar register stay in this module.

Verification
REQ-029 Scalar beat wis=1, rd=5, sop=eop=1 -> next cycle gpr_we=1, gpr_rd=5, rel_valid=1, rel_reg=5, rel_is_vec=0.
REQ-030 Four vector beats vd=8, lane_id 0..3, last eop, vrf_ready=1 -> four VRF writes in lane order, then one release vd=8, rel_is_vec=1.
REQ-031 vrf_ready=0, five vector beats (FIFO_DEPTH=4) -> err_overflow=1, fifth beat absent, first four retire once vrf_ready=1.
REQ-032 Scalar eop beat arriving in the cycle a vector eop retires -> scalar release first, vector release one cycle later.
REQ-033 Beat with sop=0 on an idle wis -> err_seq=1 and beat still written.
REQ-034 reset asserted with 3 entries queued -> vrf_valid=0, no rel_valid, and the FIFO is empty after reset.
